// File: rtl/mips_pkg.sv
// mips_pkg: shared load-type codes, FSM state encodings and default datapath width
package mips_pkg;
  localparam int DW_DEF = 32;
  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } ldtype_t;
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword of a load word and sign/zero-extends it
module load_extend
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] rdata,
  input  logic [2:0]    ldtype,
  input  logic [1:0]    addr_lo,
  output logic [DW-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr_lo, 3'b000} +: 8];
  assign h = rdata[{addr_lo[1], 4'b0000} +: 16];
  assign data = ldtype == LD_LB  ? {{(DW-8){b[7]}}, b}   :
                ldtype == LD_LBU ? {{(DW-8){1'b0}}, b}   :
                ldtype == LD_LH  ? {{(DW-16){h[15]}}, h} :
                ldtype == LD_LHU ? {{(DW-16){1'b0}}, h}  : rdata;
endmodule

// File: rtl/wb_forward_source.sv
// wb_forward_source: MEM/WB register producing WB write data, stalling on slow data-memory loads
module wb_forward_source
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic          mem_flush,
  input  logic          mem_regwrite,
  input  logic [4:0]    mem_wbadd,
  input  logic [DW-1:0] mem_alu,
  input  logic          mem_is_load,
  input  logic [2:0]    mem_ldtype,
  input  logic [1:0]    mem_addr_lo,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ready,
  output logic          mem_stall,
  output logic [4:0]    WBwbadd,
  output logic          WBregwrite,
  output logic [DW-1:0] fordata
);
  state_t state, next;
  logic accept, ld_done, alu_done, cap;
  logic [DW-1:0] ext;
  load_extend #(.DW(DW)) u_ext (
    .rdata  (dmem_rdata),
    .ldtype (mem_ldtype),
    .addr_lo(mem_addr_lo),
    .data   (ext)
  );
  assign accept   = mem_valid && !mem_flush;
  // in WAIT_MEM the upstream holds the load stable, so only flush and ready matter
  assign ld_done  = state == IDLE ? accept && mem_is_load && dmem_ready : !mem_flush && dmem_ready;
  assign alu_done = state == IDLE && accept && !mem_is_load;
  assign cap      = ld_done || alu_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next;
  always_comb begin
    next = state;
    if (state == IDLE) next = accept && mem_is_load && !dmem_ready ? WAIT_MEM : IDLE;
    else               next = mem_flush || dmem_ready ? IDLE : WAIT_MEM;
  end
  always_comb begin
    mem_stall = 1'b0;
    if (rst_n)
      mem_stall = state == IDLE ? accept && mem_is_load && !dmem_ready : !mem_flush && !dmem_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      WBregwrite <= 1'b0;
      WBwbadd    <= '0;
      fordata    <= '0;
    end else begin
      WBregwrite <= cap && mem_regwrite && mem_wbadd != 5'd0;
      if (cap) begin
        WBwbadd <= mem_wbadd;
        fordata <= ld_done ? ext : mem_alu;
      end
    end
endmodule
